// File: rtl/VX_raster_pkg.sv
// Shared raster back-end types: the block payload handed to the block
// evaluators and the dispatch FSM state encoding.
package VX_raster_pkg;

  localparam int VX_RASTER_DIM_BITS = 8;
  localparam int VX_RASTER_PID_BITS = 8;
  localparam int RASTER_DATA_BITS   = 16;

  typedef struct packed {
    logic [VX_RASTER_DIM_BITS-1:0]   xloc;
    logic [VX_RASTER_DIM_BITS-1:0]   yloc;
    logic [VX_RASTER_DIM_BITS-1:0]   xmin;
    logic [VX_RASTER_DIM_BITS-1:0]   xmax;
    logic [VX_RASTER_DIM_BITS-1:0]   ymin;
    logic [VX_RASTER_DIM_BITS-1:0]   ymax;
    logic [VX_RASTER_PID_BITS-1:0]   pid;
    logic [8:0][RASTER_DATA_BITS-1:0] edges;
  } block_t;

  localparam int BLOCK_BITS = $bits(block_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } dispatch_state_e;

endpackage

// File: rtl/VX_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr; the
// pointer moves past the granted requester only when the grant is consumed.
module VX_rr_arbiter #(
  parameter int NUM_REQS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                unlock,
  output logic                grant_valid,
  output logic [NUM_REQS-1:0] grant_onehot
);

  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQS);

  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    offset;
  logic [IDX_W-1:0]    grant_index;
  logic [NUM_REQS-1:0] req_rot;
  logic [IDX_W:0]      idx_sum;
  logic [IDX_W:0]      next_sum;

  // Rotating the requests puts rr_ptr at bit 0, so a plain priority pick works.
  assign req_rot     = NUM_REQS'({requests, requests} >> rr_ptr);
  assign grant_valid = |requests;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    offset = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = IDX_W'(i);
    end
    idx_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (idx_sum >= NUM_W) idx_sum = idx_sum - NUM_W;
    grant_index = idx_sum[IDX_W-1:0];
    next_sum    = idx_sum + (IDX_W+1)'(1);
    grant_onehot = '0;
    if (grant_valid) grant_onehot[grant_index] = 1'b1;
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (unlock && grant_valid) begin
      rr_ptr <= (next_sum == NUM_W) ? '0 : next_sum[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/raster_be_dispatch.sv
// Block dispatcher: registers each incoming raster block once, hands it to a
// ready BE lane in round-robin order and tracks batch start/drain/done.
module raster_be_dispatch
  import VX_raster_pkg::*;
#(
  parameter int NUM_BES       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic                  valid_in,
  input  logic                  last_in,
  input  logic [BLOCK_BITS-1:0] block_in,
  output logic                  ready_in,
  output logic [NUM_BES-1:0]    be_valid_out,
  output logic [BLOCK_BITS-1:0] be_block_out,
  input  logic [NUM_BES-1:0]    be_ready_in,
  input  logic [NUM_BES-1:0]    be_busy_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [31:0]           perf_stalls_out
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  dispatch_state_e       state;
  dispatch_state_e       state_next;
  logic                  in_run;
  logic                  stage_valid;
  logic [BLOCK_BITS-1:0] stage_block;
  logic                  last_pending;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  grant_valid;
  logic [NUM_BES-1:0]    grant_onehot;
  logic                  stage_fire;
  logic                  in_fire;
  logic                  lanes_idle;

  VX_rr_arbiter #(
    .NUM_REQS (NUM_BES)
  ) lane_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (be_ready_in),
    .unlock       (stage_fire),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot)
  );

  assign stage_fire   = stage_valid && grant_valid;
  assign ready_in     = in_run && !last_pending && (!stage_valid || stage_fire);
  assign in_fire      = valid_in && ready_in;
  assign be_valid_out = stage_valid ? grant_onehot : '0;
  assign be_block_out = stage_block;
  assign lanes_idle   = !stage_valid && (be_busy_in == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_in) state_next = ST_RUN;
      ST_RUN:   if (last_pending && (!stage_valid || stage_fire)) state_next = ST_DRAIN;
      ST_DRAIN: if (lanes_idle && settle_cnt == SETTLE_LAST) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_run   = (state == ST_RUN);
    busy_out = (state != ST_IDLE);
    done_out = (state == ST_DONE);
  end

  // NOTE: the payload register is reset too, so be_block_out reads 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid     <= 1'b0;
      stage_block     <= '0;
      last_pending    <= 1'b0;
      settle_cnt      <= '0;
      perf_stalls_out <= '0;
    end else begin
      if (in_fire) begin
        stage_valid <= 1'b1;
        stage_block <= block_in;
      end else if (stage_fire) begin
        stage_valid <= 1'b0;
      end

      last_pending <= in_run && (last_pending || (in_fire && last_in));

      // The settle window covers the cycle of BE pipe latency before busy rises.
      if (state != ST_DRAIN || !lanes_idle) settle_cnt <= '0;
      else if (settle_cnt != SETTLE_LAST)   settle_cnt <= settle_cnt + SETTLE_W'(1);

      if (stage_valid && !grant_valid && perf_stalls_out != '1)
        perf_stalls_out <= perf_stalls_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_raster_be_dispatch.sv
// Bench for raster_be_dispatch: randomized traffic compared every cycle against
// a transaction-level model, plus directed checks with hand-computed values.
`timescale 1ns/1ps
module tb_raster_be_dispatch;
  import VX_raster_pkg::*;

  localparam int NB = 4;
  localparam int LW = 2;
  localparam int SC = 2;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          start_in  = 1'b0;
  logic          valid_in  = 1'b0;
  logic          last_in   = 1'b0;
  block_t        block_in  = '0;
  logic          ready_in;
  logic [NB-1:0] be_valid_out;
  block_t        be_block_out;
  logic [NB-1:0] be_ready_in = '0;
  logic [NB-1:0] be_busy_in  = '0;
  logic          busy_out;
  logic          done_out;
  logic [31:0]   perf_stalls_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: batch phase, stage contents as a queue, round-robin pointer.
  int     m_phase;
  block_t m_stage[$];
  bit     m_last;
  int     m_ptr;
  int     m_idle_run;
  longint m_stalls;
  block_t m_payload;

  int lane_log[$];
  int lane_cyc[$];
  int fire_cyc[$];
  int done_cyc[$];

  raster_be_dispatch #(
    .NUM_BES       (NB),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_in        (start_in),
    .valid_in        (valid_in),
    .last_in         (last_in),
    .block_in        (block_in),
    .ready_in        (ready_in),
    .be_valid_out    (be_valid_out),
    .be_block_out    (be_block_out),
    .be_ready_in     (be_ready_in),
    .be_busy_in      (be_busy_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .perf_stalls_out (perf_stalls_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_reset();
    m_phase    = P_IDLE;
    m_stage.delete();
    m_last     = 1'b0;
    m_ptr      = 0;
    m_idle_run = 0;
    m_stalls   = 0;
    m_payload  = '0;
  endfunction

  function automatic int grant_lane();
    for (int k = 0; k < NB; k++) begin
      int j = (m_ptr + k) % NB;
      if (be_ready_in[j[LW-1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic void model_step(int g, bit rdy);
    bit fire = valid_in && rdy;
    if (m_stage.size() != 0 && be_ready_in == '0 && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (m_stage.size() != 0 && g >= 0) begin
      void'(m_stage.pop_front());
      m_ptr = (g + 1) % NB;
    end
    if (fire) begin
      m_stage.push_back(block_in);
      m_payload = block_in;
    end
    case (m_phase)
      P_IDLE: if (start_in) begin m_phase = P_RUN; m_last = 1'b0; end
      P_RUN: begin
        if (m_last && m_stage.size() == 0) begin
          m_phase = P_DRAIN;
          m_idle_run = 0;
        end else if (fire && last_in) begin
          m_last = 1'b1;
        end
      end
      P_DRAIN: begin
        if (be_busy_in == '0 && m_stage.size() == 0) begin
          m_idle_run++;
          if (m_idle_run >= SC) m_phase = P_DONE;
        end else begin
          m_idle_run = 0;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endfunction

  // Single compare process: outputs are sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    int g;
    bit exp_rdy;
    logic [NB-1:0] exp_vld;
    if (!reset) model_reset();
    g = grant_lane();
    exp_rdy = (m_phase == P_RUN) && !m_last && (m_stage.size() == 0 || g >= 0);
    exp_vld = (m_stage.size() != 0 && g >= 0) ? (NB'(1) << g) : '0;
    check("ready_in", ready_in, exp_rdy);
    check("be_valid_out", be_valid_out, exp_vld);
    check("be_block_out", be_block_out, m_payload);
    check("busy_out", busy_out, m_phase != P_IDLE);
    check("done_out", done_out, m_phase == P_DONE);
    check("perf_stalls_out", perf_stalls_out, m_stalls[31:0]);
    if (valid_in && ready_in) fire_cyc.push_back(cyc);
    if (done_out) done_cyc.push_back(cyc);
    if ((be_valid_out & be_ready_in) != '0) begin
      for (int k = 0; k < NB; k++) begin
        if (be_valid_out[k[LW-1:0]]) begin
          lane_log.push_back(k);
          lane_cyc.push_back(cyc);
        end
      end
    end
    if (reset) model_step(g, exp_rdy);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic block_t rand_block();
    block_t b;
    b.xloc = VX_RASTER_DIM_BITS'($urandom);
    b.yloc = VX_RASTER_DIM_BITS'($urandom);
    b.xmin = VX_RASTER_DIM_BITS'($urandom);
    b.xmax = VX_RASTER_DIM_BITS'($urandom);
    b.ymin = VX_RASTER_DIM_BITS'($urandom);
    b.ymax = VX_RASTER_DIM_BITS'($urandom);
    b.pid  = VX_RASTER_PID_BITS'($urandom);
    for (int e = 0; e < 9; e++) b.edges[e] = RASTER_DATA_BITS'($urandom);
    return b;
  endfunction

  function automatic logic [NB-1:0] rnd_ready(int pct);
    return ($urandom_range(0, 99) < pct) ? NB'($urandom) : '0;
  endfunction

  task automatic clear_logs();
    lane_log.delete();
    lane_cyc.delete();
    fire_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic wait_done(input string name, output int dcyc);
    int k = 0;
    while (done_cyc.size() == 0 && k < 40) begin
      tick();
      k++;
    end
    check({name, "_done_seen"}, done_cyc.size() != 0, 1'b1);
    dcyc = (done_cyc.size() != 0) ? done_cyc[0] : -1;
  endtask

  task automatic send_block(input bit last, input int pct, output bit ok);
    int n0 = fire_cyc.size();
    int k  = 0;
    valid_in = 1'b1;
    last_in  = last;
    block_in = rand_block();
    while (fire_cyc.size() == n0 && k < 100) begin
      be_ready_in = rnd_ready(pct);
      be_busy_in  = NB'($urandom);
      start_in    = ($urandom_range(0, 9) == 0);
      tick();
      k++;
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
    start_in = 1'b0;
    ok = (fire_cyc.size() != n0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit     ok;
    int     c0, bf, dcyc, n;
    block_t held;

    // Reset values.
    tick();
    #2;
    check("rst_ready", ready_in, 1'b0);
    check("rst_valid", be_valid_out, '0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_perf", perf_stalls_out, 32'd0);
    check("rst_block", be_block_out, '0);
    tick();
    tick();
    reset = 1'b1;

    // valid_in in IDLE is ignored.
    be_ready_in = '1;
    valid_in = 1'b1;
    block_in = rand_block();
    tick();
    check("idle_ready", ready_in, 1'b0);
    check("idle_no_dispatch", be_valid_out, '0);
    tick();
    valid_in = 1'b0;

    // Start, then 8 back-to-back blocks with all lanes ready.
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("ready_after_start", ready_in, 1'b1);
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1;
      block_in = rand_block();
      start_in = (i == 3);
      tick();
    end
    valid_in = 1'b0;
    start_in = 1'b0;
    tick();
    tick();
    check("rr_fire_count", fire_cyc.size(), 8);
    check("rr_dispatch_count", lane_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < lane_log.size() && fire_cyc.size() != 0) begin
        check("rr_lane", lane_log[i], i % 4);
        check("rr_lane_cycle", lane_cyc[i], fire_cyc[0] + 1 + i);
      end
    end

    // Only lane 2 ready.
    be_ready_in = 4'b0100;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      block_in = rand_block();
      tick();
    end
    valid_in = 1'b0;
    tick();
    tick();
    check("lane2_count", lane_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < lane_log.size()) check("lane2_lane", lane_log[i], 2);
    end
    check("lane2_no_stall", perf_stalls_out, 32'd0);

    // No lane ready for 5 cycles with the stage holding a block.
    be_ready_in = '0;
    held = rand_block();
    block_in = held;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    block_in = rand_block();
    repeat (5) tick();
    check("stall_count", perf_stalls_out, 32'd5);
    check("stall_payload", be_block_out, held);
    check("stall_no_valid", be_valid_out, '0);
    be_ready_in = '1;
    tick();

    // Randomized traffic within the batch.
    repeat (300) begin
      valid_in    = $urandom_range(0, 1);
      block_in    = rand_block();
      be_ready_in = rnd_ready(75);
      be_busy_in  = NB'($urandom);
      start_in    = ($urandom_range(0, 15) == 0);
      tick();
    end
    valid_in    = 1'b0;
    start_in    = 1'b0;
    be_ready_in = '1;
    be_busy_in  = '0;
    tick();
    tick();

    // Last block, lane 1 busy for 6 cycles, then drain.
    clear_logs();
    valid_in = 1'b1;
    last_in  = 1'b1;
    block_in = rand_block();
    c0 = cyc;
    tick();
    valid_in   = 1'b0;
    last_in    = 1'b0;
    be_busy_in = 4'b0010;
    check("ready_after_last", ready_in, 1'b0);
    if (fire_cyc.size() != 0) check("last_fire_cycle", fire_cyc[0], c0);
    repeat (6) tick();
    be_busy_in = '0;
    bf = cyc;
    wait_done("drain", dcyc);
    check("drain_done_delay", dcyc - bf, SC);
    check("drain_idle_busy", busy_out, 1'b0);
    check("drain_idle_ready", ready_in, 1'b0);

    // Busy glitch during drain restarts the settle window.
    clear_logs();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    valid_in = 1'b1;
    last_in  = 1'b1;
    block_in = rand_block();
    tick();
    valid_in   = 1'b0;
    last_in    = 1'b0;
    be_busy_in = 4'b0010;
    tick();
    tick();
    be_busy_in = '0;
    tick();
    be_busy_in = 4'b0010;
    tick();
    be_busy_in = '0;
    bf = cyc;
    wait_done("glitch", dcyc);
    check("glitch_done_delay", dcyc - bf, SC);

    // Random batches, checked entirely by the model.
    for (int b = 0; b < 3; b++) begin
      clear_logs();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        send_block(i == n - 1, 70, ok);
        check("batch_send", ok, 1'b1);
      end
      be_ready_in = '1;
      repeat ($urandom_range(0, 6)) begin
        be_busy_in = NB'($urandom);
        tick();
      end
      be_busy_in = '0;
      wait_done("batch", dcyc);
    end

    // Asynchronous reset mid-RUN with the stage holding a block.
    clear_logs();
    start_in = 1'b1;
    tick();
    start_in    = 1'b0;
    be_ready_in = 4'b0010;
    valid_in    = 1'b1;
    block_in    = rand_block();
    tick();
    block_in = rand_block();
    tick();
    valid_in    = 1'b0;
    be_ready_in = '0;
    #1;
    check("pre_reset_ready", ready_in, 1'b0);
    if (lane_log.size() != 0) check("pre_reset_lane", lane_log[0], 1);
    #1;
    reset = 1'b0;
    #1;
    check("areset_ready", ready_in, 1'b0);
    check("areset_valid", be_valid_out, '0);
    check("areset_busy", busy_out, 1'b0);
    check("areset_done", done_out, 1'b0);
    check("areset_perf", perf_stalls_out, 32'd0);
    check("areset_block", be_block_out, '0);
    tick();
    reset = 1'b1;
    be_ready_in = '1;
    clear_logs();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    valid_in = 1'b1;
    block_in = rand_block();
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    check("post_reset_dispatches", lane_log.size(), 1);
    if (lane_log.size() != 0) check("post_reset_lane", lane_log[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
